// File: rtl/snuld_pkg.sv
// -----------------------------------------------------------------------------
// snuld_pkg
//   Definitions shared by the fetch stage and the controller:
//   - fetch FSM state encoding (FETCH / WAIT / DECODE)
//   - instruction register field positions
//   - instruction mode constants
//   - helper that sign-extends the 4-bit immediate field
// -----------------------------------------------------------------------------
package snuld_pkg;

    // Fetch FSM state encoding
    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;

    // Instruction register field positions (LSB of each 2-bit field)
    localparam int unsigned IR_MODE_LSB = 6;
    localparam int unsigned IR_OP_LSB   = 4;
    localparam int unsigned IR_RS_LSB   = 2;
    localparam int unsigned IR_RT_LSB   = 0;

    // Instruction modes (IR[7:6])
    localparam logic [1:0] MODE_JMP = 2'b00;
    localparam logic [1:0] MODE_LD  = 2'b01;
    localparam logic [1:0] MODE_ST  = 2'b10;
    localparam logic [1:0] MODE_ALU = 2'b11;

    // Immediate is the low nibble of the instruction, sign-extended to a byte
    function automatic logic [7:0] sext_imm4(input logic [3:0] nib);
        return {{4{nib[3]}}, nib};
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg
//   Program counter register for the fetch stage.
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   synchronous active-high reset, loads RESET_PC
//     advance_i  in   instruction accepted by execute: update pc this cycle
//     load_i     in   with advance_i: take branch target instead of pc+1
//     target_i   in   branch target
//     pc_o       out  current program counter
// -----------------------------------------------------------------------------
module fetch_pc_reg #(
    parameter int unsigned          ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Sequential increment wraps naturally at 2^ADDR_W
    always_comb begin
        pc_d = pc_q;
        if (advance_i) begin
            pc_d = load_i ? target_i : pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Front-end stage: fetches one 8-bit instruction per step over a req/valid
//   handshake, latches it in IR and presents decoded fields with inst_valid
//   until execute acknowledges, then advances or branches the PC.
//   Ports:
//     clk, reset            clock / synchronous active-high reset
//     halt                  blocks new fetches (FETCH -> WAIT)
//     imem_req, imem_addr   one-cycle fetch request, address = pc
//     imem_valid, imem_rdata response strobe and instruction byte
//     inst_valid            IR holds an instruction awaiting execute
//     mode/opcode/rs/rt/imm decoded IR fields
//     pc_out                address of the instruction in IR
//     exec_ack, pc_write, pc_target  execute handshake and branch request
// -----------------------------------------------------------------------------
module instruction_fetch
    import snuld_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [7:0]        imem_rdata,
    output logic              inst_valid,
    output logic [1:0]        mode,
    output logic [1:0]        opcode,
    output logic [1:0]        rs,
    output logic [1:0]        rt,
    output logic [7:0]        imm,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              exec_ack,
    input  logic              pc_write,
    input  logic [ADDR_W-1:0] pc_target
);

    logic [1:0]        state_q, state_d;
    logic [7:0]        ir_q, ir_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [ADDR_W-1:0] pc;
    logic              ack_take;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .advance_i (ack_take),
        .load_i    (pc_write),
        .target_i  (pc_target),
        .pc_o      (pc)
    );

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        pc_out_d = pc_out_q;
        ack_take = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (!halt) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_valid) begin
                    ir_d     = imem_rdata;
                    pc_out_d = pc;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (exec_ack) begin
                    ack_take = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            ir_q     <= '0;
            pc_out_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            pc_out_q <= pc_out_d;
        end
    end

    // Request is combinational so it can rise the cycle right after an ack;
    // gated by reset so no request escapes while reset is held.
    assign imem_req   = (state_q == ST_FETCH) && !halt && !reset;
    assign imem_addr  = pc;
    assign inst_valid = (state_q == ST_DECODE);
    assign pc_out     = pc_out_q;

    assign mode   = ir_q[IR_MODE_LSB +: 2];
    assign opcode = ir_q[IR_OP_LSB   +: 2];
    assign rs     = ir_q[IR_RS_LSB   +: 2];
    assign rt     = ir_q[IR_RT_LSB   +: 2];
    assign imm    = sext_imm4(ir_q[3:0]);

endmodule
